y86_writeback: RTL and testbench

- Write-back stage of the pipelined Y86-64 core: the W pipeline register plus retirement control.
- It is the writer that drives the register file's two write ports (dstE/valE, dstM/valM). It also supplies the W-stage forwarding sources to decode and the processor status.
- Owns the halt state machine. Suppresses writes from exceptional or bubbled instructions, and resolves dstE/dstM collisions before they reach the register file.

---
 rtl/y86_pkg.sv | 55 +++++
 rtl/y86_wreg.sv | 60 ++++++
 rtl/y86_writeback.sv | 111 +++++++++++
 tb/tb_y86_writeback.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: constants and types shared by the Y86-64 pipeline stages.
//   - Status codes carried with every instruction (SBUB..SINS).
//   - Instruction codes (INOP, IRRMOVQ, ...) and the "no register" id RNONE.
//   - wCtl_t: control half of a W-style pipeline register (stat, icode,
//     dstE, dstM). valE/valM travel next to it as separate vectors because
//     their width is a module parameter.
//   - Helper functions for status classification.
package y86_pkg;

  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [2:0] stat;
    logic [3:0] icode;
    logic [3:0] dstE;
    logic [3:0] dstM;
  } wCtl_t;

  localparam wCtl_t BUBBLE_CTL = '{stat: SBUB, icode: INOP, dstE: RNONE, dstM: RNONE};

  typedef enum logic {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wbState_t;

  // HLT, ADR, INS and the undefined codes 5..7 all stop the machine.
  function automatic logic isHaltCode(input logic [2:0] s);
    return (s >= SHLT);
  endfunction

  // Undefined status codes are reported as INS.
  function automatic logic [2:0] normStat(input logic [2:0] s);
    return (s > SINS) ? SINS : s;
  endfunction

endpackage

// File: rtl/y86_wreg.sv
// y86_wreg: W pipeline register.
//   clock, reset (async, active-low)  -- reset loads a bubble
//   enable   : register may change this edge (frozen otherwise)
//   stall    : hold current contents (highest priority)
//   bubble   : load a bubble
//   inCtl/inCnd/inValE/inValM : incoming instruction from M
//   outCtl/outValE/outValM    : stored instruction
// On a normal load dstE is cleared for a not-taken cmov and when it collides
// with dstM, so the register file never sees two writes to one register.
import y86_pkg::*;

module y86_wreg #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            stall,
  input  logic            bubble,
  input  wCtl_t           inCtl,
  input  logic            inCnd,
  input  logic [XLEN-1:0] inValE,
  input  logic [XLEN-1:0] inValM,
  output wCtl_t           outCtl,
  output logic [XLEN-1:0] outValE,
  output logic [XLEN-1:0] outValM
);

  wCtl_t loadCtl;

  always_comb begin
    loadCtl = inCtl;
    if (inCtl.icode == IRRMOVQ && !inCnd) begin
      loadCtl.dstE = RNONE;
    end
    // Memory result wins on a collision (popq %rsp leaves the popped value).
    if (loadCtl.dstE == loadCtl.dstM && loadCtl.dstE != RNONE) begin
      loadCtl.dstE = RNONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outCtl  <= BUBBLE_CTL;
      outValE <= '0;
      outValM <= '0;
    end else if (enable && !stall) begin
      if (bubble) begin
        outCtl  <= BUBBLE_CTL;
        outValE <= '0;
        outValM <= '0;
      end else begin
        outCtl  <= loadCtl;
        outValE <= inValE;
        outValM <= inValM;
      end
    end
  end

endmodule

// File: rtl/y86_writeback.sv
// y86_writeback: write-back stage of the pipelined Y86-64 core.
//   clock, reset (async, active-low)
//   m_*            : instruction leaving the M stage
//   W_stall/W_bubble : pipeline control for the W register
//   w_dstE/w_valE, w_dstM/w_valM : register-file write ports and W-stage
//                    forwarding sources (ids are F unless the instruction in
//                    W is AOK and the core is running)
//   w_icode        : icode held in W
//   stat, halted   : processor status, sticky once halted
//   retired        : saturating count of AOK instructions leaving W
import y86_pkg::*;

module y86_writeback #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       m_icode,
  input  logic             m_cnd,
  input  logic [3:0]       m_dstE,
  input  logic [3:0]       m_dstM,
  input  logic [XLEN-1:0]  m_valE,
  input  logic [XLEN-1:0]  m_valM,
  input  logic             W_stall,
  input  logic             W_bubble,
  output logic [3:0]       w_dstE,
  output logic [XLEN-1:0]  w_valE,
  output logic [3:0]       w_dstM,
  output logic [XLEN-1:0]  w_valM,
  output logic [3:0]       w_icode,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  wbState_t   state;
  logic [2:0] haltStat;
  logic       haltedReg;
  logic [CNT_W-1:0] retiredCnt;

  wCtl_t mCtl;
  wCtl_t wCtl;
  logic  running;
  logic  commit;

  assign mCtl = '{stat: m_stat, icode: m_icode, dstE: m_dstE, dstM: m_dstM};
  assign running = (state == WB_RUN);

  y86_wreg #(
    .XLEN(XLEN)
  ) wReg (
    .clock  (clock),
    .reset  (reset),
    .enable (running),
    .stall  (W_stall),
    .bubble (W_bubble),
    .inCtl  (mCtl),
    .inCnd  (m_cnd),
    .inValE (m_valE),
    .inValM (m_valM),
    .outCtl (wCtl),
    .outValE(w_valE),
    .outValM(w_valM)
  );

  // The FSM looks only at W.stat, so a stalled halting instruction still halts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= WB_RUN;
      haltStat   <= SAOK;
      haltedReg  <= 1'b0;
      retiredCnt <= '0;
    end else begin
      case (state)
        WB_RUN: begin
          if (wCtl.stat == SAOK && !W_stall && retiredCnt != '1) begin
            retiredCnt <= retiredCnt + CNT_W'(1);
          end
          if (isHaltCode(wCtl.stat)) begin
            state     <= WB_HALTED;
            haltStat  <= normStat(wCtl.stat);
            haltedReg <= 1'b1;
          end
        end
        default: begin
          // HALTED: only reset leaves this state.
          state <= WB_HALTED;
        end
      endcase
    end
  end

  // Exceptional, bubbled or post-halt instructions never reach the regfile.
  assign commit  = running && (wCtl.stat == SAOK);
  assign w_dstE  = commit ? wCtl.dstE : RNONE;
  assign w_dstM  = commit ? wCtl.dstM : RNONE;
  assign w_icode = wCtl.icode;

  always_comb begin
    stat = haltStat;
    if (running) begin
      stat = (wCtl.stat == SBUB) ? SAOK : normStat(wCtl.stat);
    end
  end

  assign halted  = haltedReg;
  assign retired = retiredCnt;

endmodule

// File: tb/tb_y86_writeback.sv
module tb_y86_writeback;

  localparam int XLEN  = 64;
  localparam int CNT_W = 6;
  localparam logic [3:0] F = 4'hF;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic [2:0]       m_stat;
  logic [3:0]       m_icode;
  logic             m_cnd;
  logic [3:0]       m_dstE;
  logic [3:0]       m_dstM;
  logic [XLEN-1:0]  m_valE;
  logic [XLEN-1:0]  m_valM;
  logic             W_stall;
  logic             W_bubble;
  logic [3:0]       w_dstE;
  logic [XLEN-1:0]  w_valE;
  logic [3:0]       w_dstM;
  logic [XLEN-1:0]  w_valM;
  logic [3:0]       w_icode;
  logic [2:0]       stat;
  logic             halted;
  logic [CNT_W-1:0] retired;

  y86_writeback #(
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .m_stat  (m_stat),
    .m_icode (m_icode),
    .m_cnd   (m_cnd),
    .m_dstE  (m_dstE),
    .m_dstM  (m_dstM),
    .m_valE  (m_valE),
    .m_valM  (m_valM),
    .W_stall (W_stall),
    .W_bubble(W_bubble),
    .w_dstE  (w_dstE),
    .w_valE  (w_valE),
    .w_dstM  (w_dstM),
    .w_valM  (w_valM),
    .w_icode (w_icode),
    .stat    (stat),
    .halted  (halted),
    .retired (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file driven by the DUT's write ports (M port written last).
  logic        clearRegs;
  logic [63:0] tbRegs [15];
  always @(posedge clock) begin
    if (clearRegs) begin
      for (int i = 0; i < 15; i++) tbRegs[i] <= '0;
    end else begin
      if (w_dstE != F) tbRegs[w_dstE] <= w_valE;
      if (w_dstM != F) tbRegs[w_dstM] <= w_valM;
    end
  end

  // ---------------- reference model ----------------
  // Architectural view: the instruction sitting in W, halt flag, latched
  // status, retirement count and the register file contents it implies.
  logic [2:0]  wStat;
  logic [3:0]  wIcode, wDstE, wDstM;
  logic [63:0] wValE, wValM;
  bit          mHalted;
  logic [2:0]  mLatched;
  int          mRetired;
  logic [63:0] mRegs [15];

  typedef struct packed {
    logic [3:0]        dstE;
    logic [63:0]       valE;
    logic [3:0]        dstM;
    logic [63:0]       valM;
    logic [3:0]        icode;
    logic [2:0]        stat;
    logic              halted;
    logic [CNT_W-1:0]  retired;
    logic [14:0][63:0] regs;
  } exp_t;

  exp_t expQ [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void modelReset();
    wStat = 3'd0; wIcode = 4'd1; wDstE = F; wDstM = F; wValE = '0; wValM = '0;
    mHalted = 0; mLatched = 3'd1; mRetired = 0;
  endfunction

  function automatic logic [2:0] reportCode(input logic [2:0] s);
    if (s == 3'd0) return 3'd1;
    if (s > 3'd4) return 3'd4;
    return s;
  endfunction

  // One rising edge, using the inputs presented before it.
  function automatic void modelEdge();
    logic [3:0] effE;
    if (mHalted) return;
    if (wStat == 3'd1) begin
      if (wDstE != F) mRegs[wDstE] = wValE;
      if (wDstM != F) mRegs[wDstM] = wValM;
      if (!W_stall && mRetired < CNT_MAX) mRetired++;
    end
    if (wStat >= 3'd2) begin
      mHalted = 1;
      mLatched = reportCode(wStat);
    end
    if (!W_stall) begin
      if (W_bubble) begin
        wStat = 3'd0; wIcode = 4'd1; wDstE = F; wDstM = F; wValE = '0; wValM = '0;
      end else begin
        effE = m_dstE;
        if (m_icode == 4'd2 && !m_cnd) effE = F;
        if (effE == m_dstM) effE = F;
        wStat = m_stat; wIcode = m_icode; wDstE = effE; wDstM = m_dstM;
        wValE = m_valE; wValM = m_valM;
      end
    end
  endfunction

  function automatic exp_t expNow();
    exp_t e;
    bit live;
    live = !mHalted && (wStat == 3'd1);
    e.dstE    = live ? wDstE : F;
    e.dstM    = live ? wDstM : F;
    e.valE    = wValE;
    e.valM    = wValM;
    e.icode   = wIcode;
    e.stat    = mHalted ? mLatched : reportCode(wStat);
    e.halted  = mHalted;
    e.retired = CNT_W'(mRetired);
    for (int i = 0; i < 15; i++) e.regs[i] = mRegs[i];
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      exp_t e;
      int badReg;
      e = expQ.pop_front();
      chk("w_dstE", 64'(w_dstE), 64'(e.dstE));
      chk("w_valE", w_valE, e.valE);
      chk("w_dstM", 64'(w_dstM), 64'(e.dstM));
      chk("w_valM", w_valM, e.valM);
      chk("w_icode", 64'(w_icode), 64'(e.icode));
      chk("stat", 64'(stat), 64'(e.stat));
      chk("halted", 64'(halted), 64'(e.halted));
      chk("retired", 64'(retired), 64'(e.retired));
      badReg = -1;
      for (int i = 0; i < 15; i++) if (badReg < 0 && tbRegs[i] !== e.regs[i]) badReg = i;
      if (badReg < 0) chk("regfile", 64'd0, 64'd0 + 64'(expQ.size() * 0));
      else chk($sformatf("regfile[%0d]", badReg), tbRegs[badReg], e.regs[badReg]);
      $display("cycle t=%0t stat=%0d halted=%0d retired=%0d dstE=%0h dstM=%0h icode=%0h",
               $time, stat, halted, retired, w_dstE, w_dstM, w_icode);
    end
  end

  // ---------------- stimulus ----------------
  task automatic setIn(input logic [2:0] s, input logic [3:0] ic, input logic c,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic st, input logic bb);
    m_stat = s; m_icode = ic; m_cnd = c; m_dstE = de; m_dstM = dm;
    m_valE = ve; m_valM = vm; W_stall = st; W_bubble = bb;
  endtask

  task automatic idle();
    setIn(3'd0, 4'd1, 1'b0, F, F, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    modelEdge();
    expQ.push_back(expNow());
    #1;
  endtask

  // Async reset asserted after the falling edge, checked before any clock edge.
  task automatic resetMid();
    #5;
    reset = 1'b0;
    #1;
    modelReset();
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_dstE", 64'(w_dstE), 64'(F));
    chk("rst_dstM", 64'(w_dstM), 64'(F));
    chk("rst_icode", 64'(w_icode), 64'd1);
    chk("rst_valE", w_valE, 64'd0);
    $display("async reset at t=%0t", $time);
    #1;
    reset = 1'b1;
  endtask

  task automatic randIn();
    int r;
    logic [2:0] s;
    r = $urandom_range(0, 99);
    if (r < 70) s = 3'd1;
    else if (r < 85) s = 3'd0;
    else s = 3'($urandom_range(2, 7));
    setIn(s, 4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : F,
          {$urandom, $urandom}, {$urandom, $urandom},
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15));
  endtask

  initial begin
    int haltedTicks;
    int wait_cycles;
    reset = 1'b0;
    clearRegs = 1'b1;
    idle();
    for (int i = 0; i < 15; i++) mRegs[i] = '0;
    modelReset();
    #3;
    chk("init_stat", 64'(stat), 64'd1);
    chk("init_halted", 64'(halted), 64'd0);
    chk("init_retired", 64'(retired), 64'd0);
    chk("init_dstE", 64'(w_dstE), 64'(F));
    chk("init_dstM", 64'(w_dstM), 64'(F));
    #9;
    reset = 1'b1;
    clearRegs = 1'b0;

    // irmovq $0x10, %rax
    tick();
    setIn(3'd1, 4'd3, 1'b0, 4'd0, F, 64'h10, 64'd0, 1'b0, 1'b0); tick();
    idle(); tick(); tick();
    // cmovle not taken, then taken
    setIn(3'd1, 4'd2, 1'b0, 4'd3, F, 64'h5, 64'd0, 1'b0, 1'b0); tick();
    setIn(3'd1, 4'd2, 1'b1, 4'd3, F, 64'h5, 64'd0, 1'b0, 1'b0); tick();
    idle(); tick();
    // popq %rsp
    setIn(3'd1, 4'hB, 1'b0, 4'd4, 4'd4, 64'h108, 64'hABCD, 1'b0, 1'b0); tick();
    idle(); tick(); tick();
    // rrmovq held by stall+bubble, then released, then a lone bubble
    setIn(3'd1, 4'd2, 1'b1, 4'd1, F, 64'h77, 64'd0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      setIn(3'd1, 4'd3, 1'b0, 4'd6, F, 64'h55, 64'd0, 1'b1, 1'b1); tick();
    end
    idle(); tick();
    setIn(3'd1, 4'd3, 1'b0, 4'd7, F, 64'h66, 64'd0, 1'b0, 1'b1); tick();
    idle(); tick();
    // halt followed by irmovq to rax, inputs ignored afterwards
    setIn(3'd2, 4'd0, 1'b0, F, F, 64'd0, 64'd0, 1'b0, 1'b0); tick();
    setIn(3'd1, 4'd3, 1'b0, 4'd0, F, 64'h99, 64'd0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin randIn(); tick(); end
    resetMid();
    // address error with a stall held over it, then reset while halted
    setIn(3'd3, 4'd5, 1'b0, F, 4'd2, 64'd0, 64'h1234, 1'b0, 1'b0); tick();
    setIn(3'd1, 4'd3, 1'b0, 4'd2, F, 64'h42, 64'd0, 1'b1, 1'b0); tick();
    idle(); tick(); tick();
    resetMid();
    // counter saturation
    for (int i = 0; i < CNT_MAX + 6; i++) begin
      setIn(3'd1, 4'd3, 1'b0, 4'(i % 15), F, 64'(i), 64'd0, 1'b0, 1'b0); tick();
    end
    resetMid();
    // randomized traffic with periodic recovery from halts
    haltedTicks = 0;
    for (int n = 0; n < 400; n++) begin
      randIn(); tick();
      if (mHalted) haltedTicks++;
      if (haltedTicks > 5) begin
        resetMid();
        haltedTicks = 0;
      end
    end

    wait_cycles = 0;
    while (expQ.size() > 0 && wait_cycles < 10) begin
      @(negedge clock);
      wait_cycles++;
    end
    #1;
    chk("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
